// File: rtl/talao_emissor.sv
// Receipt transmitter: buffers priced items during a purchase, then streams the
// receipt frame byte by byte over a valid/ready link terminated by an XOR checksum.
module talao_emissor #(
    parameter int         DEPTH = 8,
    parameter logic [7:0] HDR   = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        item_valid,
    input  logic [1:0]  produto,
    input  logic [10:0] peso,
    input  logic [15:0] valor,
    input  logic        fim_compra,
    input  logic        taxa,
    input  logic [4:0]  valor_taxa,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_last,
    output logic        busy,
    output logic        full
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        COLLECT, HEADER, COUNT, ITEM, TOT_H, TOT_L, TAXA, CHK
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  count_q, count_d;
    logic [15:0] total_q, total_d;
    logic        ovf_q, ovf_d;
    logic        taxa_q, taxa_d;
    logic [4:0]  vtaxa_q, vtaxa_d;
    logic [6:0]  idx_q, idx_d;
    logic [1:0]  sub_q, sub_d;
    logic [7:0]  chk_q, chk_d;

    logic [1:0]  prodMem  [DEPTH];
    logic [10:0] pesoMem  [DEPTH];
    logic [15:0] valorMem [DEPTH];

    logic        store;
    logic        xfer;
    logic [16:0] sum;
    logic [1:0]  rdProd;
    logic [10:0] rdPeso;
    logic [15:0] rdValor;

    assign full     = (count_q == 7'(DEPTH));
    assign store    = (state_q == COLLECT) && item_valid && !full;
    assign tx_valid = (state_q != COLLECT);
    assign busy     = (state_q != COLLECT);
    assign tx_last  = (state_q == CHK);
    assign xfer     = tx_valid && tx_ready;
    assign sum      = {1'b0, total_q} + {1'b0, valor};

    // Item storage needs no reset: count_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (store) begin
            prodMem[count_q[AW-1:0]]  <= produto;
            pesoMem[count_q[AW-1:0]]  <= peso;
            valorMem[count_q[AW-1:0]] <= valor;
        end
    end

    assign rdProd  = prodMem[idx_q[AW-1:0]];
    assign rdPeso  = pesoMem[idx_q[AW-1:0]];
    assign rdValor = valorMem[idx_q[AW-1:0]];

    // Output byte depends only on registered state, so it holds while stalled.
    always_comb begin
        tx_data = 8'h00;
        case (state_q)
            HEADER: tx_data = HDR;
            COUNT:  tx_data = {ovf_q, count_q};
            ITEM: begin
                case (sub_q)
                    2'd0:    tx_data = {rdProd, 3'b000, rdPeso[10:8]};
                    2'd1:    tx_data = rdPeso[7:0];
                    2'd2:    tx_data = rdValor[15:8];
                    default: tx_data = rdValor[7:0];
                endcase
            end
            TOT_H:  tx_data = total_q[15:8];
            TOT_L:  tx_data = total_q[7:0];
            TAXA:   tx_data = {taxa_q, 2'b00, vtaxa_q};
            CHK:    tx_data = chk_q;
            default: tx_data = 8'h00;
        endcase
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        total_d = total_q;
        ovf_d   = ovf_q;
        taxa_d  = taxa_q;
        vtaxa_d = vtaxa_q;
        idx_d   = idx_q;
        sub_d   = sub_q;
        chk_d   = chk_q;

        if (state_q == COLLECT) begin
            // A same-cycle item is stored before the frame starts, so it is included.
            if (store) begin
                count_d = count_q + 7'd1;
                total_d = sum[16] ? 16'hFFFF : sum[15:0];
            end else if (item_valid) begin
                ovf_d = 1'b1;
            end
            if (fim_compra) begin
                taxa_d  = taxa;
                vtaxa_d = valor_taxa;
                idx_d   = 7'd0;
                sub_d   = 2'd0;
                chk_d   = 8'h00;
                state_d = HEADER;
            end
        end else if (xfer) begin
            chk_d = chk_q ^ tx_data;
            case (state_q)
                HEADER: state_d = COUNT;
                COUNT:  state_d = (count_q == 7'd0) ? TOT_H : ITEM;
                ITEM: begin
                    sub_d = sub_q + 2'd1;
                    if (sub_q == 2'd3) begin
                        if (idx_q == count_q - 7'd1) begin
                            state_d = TOT_H;
                        end else begin
                            idx_d = idx_q + 7'd1;
                        end
                    end
                end
                TOT_H:  state_d = TOT_L;
                TOT_L:  state_d = TAXA;
                TAXA:   state_d = CHK;
                CHK: begin
                    state_d = COLLECT;
                    count_d = 7'd0;
                    total_d = 16'h0000;
                    ovf_d   = 1'b0;
                end
                default: state_d = COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= COLLECT;
            count_q <= 7'd0;
            total_q <= 16'h0000;
            ovf_q   <= 1'b0;
            taxa_q  <= 1'b0;
            vtaxa_q <= 5'd0;
            idx_q   <= 7'd0;
            sub_q   <= 2'd0;
            chk_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            total_q <= total_d;
            ovf_q   <= ovf_d;
            taxa_q  <= taxa_d;
            vtaxa_q <= vtaxa_d;
            idx_q   <= idx_d;
            sub_q   <= sub_d;
            chk_q   <= chk_d;
        end
    end

endmodule

// File: tb/tb_talao_emissor.sv
// Scoreboard bench for talao_emissor: a purchase-level model builds each expected
// frame, and a monitor pops and compares every byte the DUT hands over.
module tb_talao_emissor;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        item_valid;
    logic [1:0]  produto;
    logic [10:0] peso;
    logic [15:0] valor;
    logic        fim_compra;
    logic        taxa;
    logic [4:0]  valor_taxa;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_last;
    logic        busy;
    logic        full;

    talao_emissor #(.DEPTH(DEPTH), .HDR(8'hA5)) dut (
        .clk(clk), .rst(rst), .item_valid(item_valid), .produto(produto),
        .peso(peso), .valor(valor), .fim_compra(fim_compra), .taxa(taxa),
        .valor_taxa(valor_taxa), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_last(tx_last), .busy(busy), .full(full)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  p;
        logic [10:0] w;
        logic [15:0] v;
    } item_t;

    item_t       mItems[$];
    int          mTotal = 0;
    bit          mOvf = 0;
    logic [7:0]  expBytes[$];
    logic [8:0]  sbQ[$];
    bit          directedFrame = 0;
    bit          readyAlways = 1;
    bit          junkOn = 0;
    int          total = 0;
    int          bad = 0;
    int          popCount = 0;
    bit          holdActive = 0;
    logic [7:0]  holdData;
    logic        holdLast;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic void modelClear();
        mItems.delete();
        mTotal = 0;
        mOvf   = 0;
    endfunction

    function automatic void modelCommit(input logic [1:0] p, input logic [10:0] w, input logic [15:0] v);
        item_t it;
        if (mItems.size() < DEPTH) begin
            it.p = p; it.w = w; it.v = v;
            mItems.push_back(it);
            mTotal = mTotal + int'(v);
            if (mTotal > 65535) mTotal = 65535;
        end else begin
            mOvf = 1;
        end
    endfunction

    function automatic void pushExp();
        for (int i = 0; i < expBytes.size(); i++)
            sbQ.push_back({(i == expBytes.size() - 1), expBytes[i]});
        expBytes.delete();
    endfunction

    function automatic void modelEmit(input logic tx, input logic [4:0] vt);
        logic [15:0] t16;
        logic [7:0]  chk;
        t16 = 16'(mTotal);
        expBytes.delete();
        expBytes.push_back(8'hA5);
        expBytes.push_back({mOvf, 7'(mItems.size())});
        foreach (mItems[i]) begin
            expBytes.push_back({mItems[i].p, 3'b000, mItems[i].w[10:8]});
            expBytes.push_back(mItems[i].w[7:0]);
            expBytes.push_back(mItems[i].v[15:8]);
            expBytes.push_back(mItems[i].v[7:0]);
        end
        expBytes.push_back(t16[15:8]);
        expBytes.push_back(t16[7:0]);
        expBytes.push_back({tx, 2'b00, vt});
        chk = 8'h00;
        foreach (expBytes[i]) chk = chk ^ expBytes[i];
        expBytes.push_back(chk);
        pushExp();
    endfunction

    // One-cycle strobe of item and/or end-of-purchase, mirrored into the model.
    task automatic applyStimulus(input logic iv, input logic [1:0] p, input logic [10:0] w,
                                 input logic [15:0] v, input logic fim, input logic tx,
                                 input logic [4:0] vt);
        bit expFull;
        @(posedge clk); #1;
        item_valid = iv; produto = p; peso = w; valor = v;
        fim_compra = fim; taxa = tx; valor_taxa = vt;
        if (iv) modelCommit(p, w, v);
        expFull = (mItems.size() == DEPTH);
        if (fim) begin
            if (directedFrame) pushExp();
            else modelEmit(tx, vt);
            directedFrame = 0;
            modelClear();
        end
        @(posedge clk); #1;
        item_valid = 0; fim_compra = 0;
        checkOutput("full", full, expFull);
        checkOutput("busy", busy, fim);
    endtask

    task automatic doReset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0;
        sbQ.delete();
        modelClear();
    endtask

    task automatic waitFrame();
        int cyc = 0;
        while (!(sbQ.size() == 0 && !tx_valid)) begin
            if (cyc >= 2000) begin
                total++; bad++;
                $display("[TB] FAIL frameTimeout: got pending=%0d expected 0", sbQ.size());
                item_valid = 0; fim_compra = 0;
                doReset();
                return;
            end
            if (junkOn && sbQ.size() >= 1) begin
                item_valid = 1'($urandom_range(0, 1));
                fim_compra = ($urandom_range(0, 3) == 0);
                produto    = 2'($urandom_range(0, 3));
                peso       = 11'($urandom);
                valor      = 16'($urandom);
                taxa       = 1'($urandom_range(0, 1));
                valor_taxa = 5'($urandom);
            end else begin
                item_valid = 0; fim_compra = 0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        item_valid = 0; fim_compra = 0;
        checkOutput("busyAfterFrame", busy, 0);
    endtask

    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            tx_ready = readyAlways ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: bytes are taken from the scoreboard only when a handshake will occur.
    always @(negedge clk) begin
        if (rst) begin
            holdActive = 0;
        end else begin
            if (tx_valid && holdActive) begin
                checkOutput("holdData", tx_data, holdData);
                checkOutput("holdLast", tx_last, holdLast);
            end
            if (tx_valid && tx_ready) begin
                holdActive = 0;
                popCount++;
                if (sbQ.size() == 0) begin
                    total++; bad++;
                    $display("[TB] FAIL unexpectedByte: got %0h expected none", tx_data);
                end else begin
                    checkOutput("byte", tx_data, sbQ[0][7:0]);
                    checkOutput("last", tx_last, sbQ[0][8]);
                    void'(sbQ.pop_front());
                end
            end else if (tx_valid) begin
                holdActive = 1;
                holdData   = tx_data;
                holdLast   = tx_last;
            end else begin
                holdActive = 0;
            end
        end
    end

    initial begin
        int base;
        int cyc;
        int n;
        logic [15:0] v;
        rst = 1'b1;
        item_valid = 0; produto = 0; peso = 0; valor = 0;
        fim_compra = 0; taxa = 0; valor_taxa = 0;
        #1;
        checkOutput("rstValid", tx_valid, 0);
        checkOutput("rstLast", tx_last, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstFull", full, 0);
        checkOutput("rstData", tx_data, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Single item, ready tied high.
        applyStimulus(1, 2'd1, 11'd500, 16'd250, 0, 0, 0);
        expBytes = '{8'hA5, 8'h01, 8'h41, 8'hF4, 8'h00, 8'hFA, 8'h00, 8'hFA, 8'h85, 8'h94};
        directedFrame = 1;
        applyStimulus(0, 0, 0, 0, 1, 1, 5'd5);
        waitFrame();

        // Empty purchase.
        expBytes = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5};
        directedFrame = 1;
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        waitFrame();

        // Overflow: ninth item dropped, flag clears with the frame.
        for (int i = 0; i < 9; i++) applyStimulus(1, 2'd2, 11'(i * 10), 16'd1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 5'd3);
        waitFrame();
        expBytes = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5};
        directedFrame = 1;
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        waitFrame();

        // Saturating total under random backpressure.
        readyAlways = 0;
        applyStimulus(1, 2'd3, 11'd2047, 16'hFFF0, 0, 0, 0);
        applyStimulus(1, 2'd3, 11'd1024, 16'hFFF0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 1, 5'd31);
        waitFrame();

        // Item together with end-of-purchase, junk while busy.
        junkOn = 1;
        applyStimulus(1, 2'd1, 11'd300, 16'd1234, 1, 0, 5'd7);
        waitFrame();
        junkOn = 0;

        // Reset after the third byte aborts the frame.
        readyAlways = 1;
        applyStimulus(1, 2'd2, 11'd100, 16'd50, 0, 0, 0);
        applyStimulus(1, 2'd1, 11'd200, 16'd60, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 1, 5'd2);
        base = popCount;
        cyc = 0;
        while (popCount < base + 3 && cyc < 200) begin
            @(posedge clk);
            cyc++;
        end
        if (cyc >= 200) begin
            total++; bad++;
            $display("[TB] FAIL midResetWait: got pops=%0d expected %0d", popCount - base, 3);
        end
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midRstValid", tx_valid, 0);
        checkOutput("midRstBusy", busy, 0);
        checkOutput("midRstLast", tx_last, 0);
        sbQ.delete();
        modelClear();
        @(negedge clk);
        rst = 1'b0;
        expBytes = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5};
        directedFrame = 1;
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        waitFrame();

        // Random purchases.
        for (int k = 0; k < 25; k++) begin
            readyAlways = 1'($urandom_range(0, 1));
            junkOn = 1;
            n = $urandom_range(0, 10);
            for (int i = 0; i < n; i++) begin
                v = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(50000, 65535)) : 16'($urandom);
                applyStimulus(1, 2'($urandom_range(1, 3)), 11'($urandom), v, 0, 0, 0);
            end
            if ($urandom_range(0, 1) == 1)
                applyStimulus(1, 2'($urandom_range(1, 3)), 11'($urandom), 16'($urandom), 1,
                              1'($urandom_range(0, 1)), 5'($urandom));
            else
                applyStimulus(0, 0, 0, 0, 1, 1'($urandom_range(0, 1)), 5'($urandom));
            waitFrame();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
